// File: rtl/mem_req_pkg.sv
// ---------------------------------------------------------------------------
// mem_req_pkg
// Shared definitions for the memory request arbiter slice: default sizes,
// the request-type encoding used on req_type / mc_type, and the helper that
// derives the requester-id width from the number of requesters.
// ---------------------------------------------------------------------------
package mem_req_pkg;

    localparam int NUM_REQ_DEFAULT    = 4;
    localparam int DATA_WIDTH_DEFAULT = 16;
    localparam int ADDR_WIDTH_DEFAULT = 30;
    localparam int TAG_DEPTH_DEFAULT  = 16;

    // Request type as carried on req_type[i] and mc_type.
    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_type_e;

    // Bits needed to name one requester; a single requester still gets one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int REQ_ID_WIDTH = id_width(NUM_REQ_DEFAULT);

endpackage

// File: rtl/mem_tag_fifo.sv
// ---------------------------------------------------------------------------
// mem_tag_fifo
// Small FIFO of requester ids, used to remember who owns each request that
// the memory controller has accepted but not yet completed. Completions come
// back in order, so the head entry always names the owner of the next one.
//
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (empties the FIFO)
//   push      : enqueue push_id (honoured when not full, or when popping too)
//   push_id   : requester id to store
//   pop       : dequeue the head entry (ignored when empty)
//   pop_id    : requester id at the head, valid while !empty
//   count     : number of entries held, 0..DEPTH
//   empty     : count == 0
// ---------------------------------------------------------------------------
module mem_tag_fifo #(
    parameter int DEPTH = 16,
    parameter int ID_W  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [ID_W-1:0]            push_id,
    input  logic                       pop,
    output logic [ID_W-1:0]            pop_id,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ID_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    // A push into a full FIFO is safe when the head leaves in the same
    // cycle: the write lands in the slot being vacated, and the old value
    // has already been read combinationally through pop_id.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign pop_id = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_id;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// ---------------------------------------------------------------------------
// mem_req_arbiter
// Round-robin arbiter that funnels NUM_REQ requesters into one memory
// controller port through a single output stage register, and routes the
// controller's in-order read/write completions back to the right requester
// using one tag FIFO per request type.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   req_valid[i]    : requester i has a request
//   req_type[i]     : 1 = write, 0 = read
//   req_addr/data   : packed per-requester fields, requester i at slice i
//   req_ready       : one-hot grant (combinational)
//   rsp_valid       : one-hot read return, rsp_data = mc_data_out
//   wr_ack          : one-hot write completion
//   mc_valid/type/addr/data : request to controller, straight from the stage
//   mc_busy         : controller cannot accept this cycle
//   mc_write_done, mc_read_done, mc_data_out : in-order completions
//   err_underflow   : sticky, a completion arrived with no tag outstanding
// ---------------------------------------------------------------------------
module mem_req_arbiter
    import mem_req_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEFAULT,
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter int TAG_DEPTH  = TAG_DEPTH_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_type,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [NUM_REQ-1:0]            wr_ack,
    output logic                          mc_valid,
    output logic                          mc_type,
    output logic [ADDR_WIDTH-1:0]         mc_addr,
    output logic [DATA_WIDTH-1:0]         mc_data,
    input  logic                          mc_busy,
    input  logic                          mc_write_done,
    input  logic                          mc_read_done,
    input  logic [DATA_WIDTH-1:0]         mc_data_out,
    output logic                          err_underflow
);

    localparam int ID_W  = id_width(NUM_REQ);
    localparam int IDX_W = ID_W + 1;
    localparam int CNT_W = $clog2(TAG_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    logic                  stage_valid;
    req_type_e             stage_type;
    logic [ADDR_WIDTH-1:0] stage_addr;
    logic [DATA_WIDTH-1:0] stage_data;
    logic [ID_W-1:0]       stage_id;

    logic [ID_W-1:0]       rr_ptr;
    logic                  xfer;
    logic                  loadable;

    logic [CNT_W-1:0]      rd_count;
    logic [CNT_W-1:0]      wr_count;
    logic [OCC_W-1:0]      rd_occ;
    logic [OCC_W-1:0]      wr_occ;
    logic                  rd_ok;
    logic                  wr_ok;

    logic [NUM_REQ-1:0]    eligible;
    logic                  grant_any;
    logic [ID_W-1:0]       grant_id;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    req_type_e             sel_type;

    logic                  rd_push;
    logic                  wr_push;
    logic                  rd_pop;
    logic                  wr_pop;
    logic                  rd_empty;
    logic                  wr_empty;
    logic [ID_W-1:0]       rd_head;
    logic [ID_W-1:0]       wr_head;

    assign mc_valid = stage_valid;
    assign mc_type  = stage_type;
    assign mc_addr  = stage_addr;
    assign mc_data  = stage_data;

    assign xfer     = stage_valid & ~mc_busy;
    assign loadable = ~stage_valid | xfer;

    // A request sitting in the stage will claim a tag as soon as it is
    // accepted, so it counts against the tag budget of its type already.
    assign rd_occ = OCC_W'(rd_count) + OCC_W'(stage_valid && (stage_type == REQ_READ));
    assign wr_occ = OCC_W'(wr_count) + OCC_W'(stage_valid && (stage_type == REQ_WRITE));
    assign rd_ok  = (rd_occ < OCC_W'(TAG_DEPTH));
    assign wr_ok  = (wr_occ < OCC_W'(TAG_DEPTH));

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] & loadable & ~rst & (req_type[i] ? wr_ok : rd_ok);
        end
    end

    // Round-robin search starting at rr_ptr, wrapping at NUM_REQ (which
    // need not be a power of two).
    always_comb begin
        logic [IDX_W-1:0] cand;
        grant_any = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + IDX_W'(k);
            if (cand >= IDX_W'(NUM_REQ)) begin
                cand = cand - IDX_W'(NUM_REQ);
            end
            if (!grant_any && eligible[cand[ID_W-1:0]]) begin
                grant_any = 1'b1;
                grant_id  = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        sel_addr  = '0;
        sel_data  = '0;
        sel_type  = REQ_READ;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_any && (grant_id == ID_W'(i))) begin
                req_ready[i] = 1'b1;
                sel_addr     = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_type     = req_type_e'(req_type[i]);
            end
        end
    end

    // A grant can only happen when the stage is loadable, so loading on
    // grant also covers the same-cycle refill after a transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_valid <= 1'b0;
            stage_type  <= REQ_READ;
            stage_addr  <= '0;
            stage_data  <= '0;
            stage_id    <= '0;
        end else if (grant_any) begin
            stage_valid <= 1'b1;
            stage_type  <= sel_type;
            stage_addr  <= sel_addr;
            stage_data  <= sel_data;
            stage_id    <= grant_id;
        end else if (xfer) begin
            stage_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end
    end

    assign rd_push = xfer & (stage_type == REQ_READ);
    assign wr_push = xfer & (stage_type == REQ_WRITE);
    assign rd_pop  = mc_read_done & ~rd_empty;
    assign wr_pop  = mc_write_done & ~wr_empty;

    mem_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .ID_W  (ID_W)
    ) u_rd_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (rd_push),
        .push_id (stage_id),
        .pop     (rd_pop),
        .pop_id  (rd_head),
        .count   (rd_count),
        .empty   (rd_empty)
    );

    mem_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .ID_W  (ID_W)
    ) u_wr_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (wr_push),
        .push_id (stage_id),
        .pop     (wr_pop),
        .pop_id  (wr_head),
        .count   (wr_count),
        .empty   (wr_empty)
    );

    assign rsp_data = mc_data_out;

    always_comb begin
        rsp_valid = '0;
        wr_ack    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = rd_pop & ~rst & (rd_head == ID_W'(i));
            wr_ack[i]    = wr_pop & ~rst & (wr_head == ID_W'(i));
        end
    end

    // Completions with no tag outstanding are dropped and flagged until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_underflow <= 1'b0;
        end else if ((mc_read_done & rd_empty) | (mc_write_done & wr_empty)) begin
            err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_req_arbiter
// Directed bench for mem_req_arbiter (default parameters). A queue-based
// reference model tracks the stage, round-robin pointer and outstanding tags
// and checks every DUT output on each falling edge; directed sequences add
// hand-computed literal expectations at the interesting points.
// ---------------------------------------------------------------------------
module tb_mem_req_arbiter;

    localparam int N     = 4;
    localparam int DW    = 16;
    localparam int AW    = 30;
    localparam int DEPTH = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_type = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic [N-1:0]    wr_ack;
    logic            mc_valid;
    logic            mc_type;
    logic [AW-1:0]   mc_addr;
    logic [DW-1:0]   mc_data;
    logic            mc_busy = 1'b0;
    logic            mc_write_done = 1'b0;
    logic            mc_read_done = 1'b0;
    logic [DW-1:0]   mc_data_out = '0;
    logic            err_underflow;

    int checks   = 0;
    int failures = 0;

    mem_req_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_type      (req_type),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .wr_ack        (wr_ack),
        .mc_valid      (mc_valid),
        .mc_type       (mc_type),
        .mc_addr       (mc_addr),
        .mc_data       (mc_data),
        .mc_busy       (mc_busy),
        .mc_write_done (mc_write_done),
        .mc_read_done  (mc_read_done),
        .mc_data_out   (mc_data_out),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] t,
                                 input logic busy, input logic wd, input logic rd,
                                 input logic [DW-1:0] dout);
        req_valid     = v;
        req_type      = t;
        mc_busy       = busy;
        mc_write_done = wd;
        mc_read_done  = rd;
        mc_data_out   = dout;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: what the arbiter must be holding and owes its requesters.
    bit          m_valid = 1'b0;
    bit          m_type  = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    int          m_id  = 0;
    int          m_rr  = 0;
    bit          m_err = 1'b0;
    int          rdq[$];
    int          wrq[$];
    int          gi;
    int          cand_i;
    int          occ_rd;
    int          occ_wr;
    bit          m_xfer;
    bit          m_load;
    logic [N-1:0] exp_rsp;
    logic [N-1:0] exp_ack;

    always @(negedge clk) begin
        if (rst) begin
            m_valid = 1'b0;
            m_rr    = 0;
            m_err   = 1'b0;
            rdq.delete();
            wrq.delete();
            checkOutput("model_rst_mc_valid", mc_valid, 0);
            checkOutput("model_rst_req_ready", req_ready, 0);
            checkOutput("model_rst_rsp_valid", rsp_valid, 0);
            checkOutput("model_rst_wr_ack", wr_ack, 0);
            checkOutput("model_rst_err", err_underflow, 0);
        end else begin
            checkOutput("model_mc_valid", mc_valid, m_valid);
            if (m_valid) begin
                checkOutput("model_mc_type", mc_type, m_type);
                checkOutput("model_mc_addr", mc_addr, m_addr);
                checkOutput("model_mc_data", mc_data, m_data);
            end
            checkOutput("model_err", err_underflow, m_err);

            m_xfer = m_valid && !mc_busy;
            m_load = !m_valid || m_xfer;
            occ_rd = rdq.size() + ((m_valid && !m_type) ? 1 : 0);
            occ_wr = wrq.size() + ((m_valid && m_type) ? 1 : 0);
            gi = -1;
            for (int k = 0; k < N; k++) begin
                cand_i = (m_rr + k) % N;
                if (gi < 0 && m_load && req_valid[cand_i] &&
                    ((req_type[cand_i] ? occ_wr : occ_rd) < DEPTH)) begin
                    gi = cand_i;
                end
            end
            checkOutput("model_req_ready", req_ready, (gi >= 0) ? (32'd1 << gi) : 32'd0);

            exp_rsp = '0;
            if (mc_read_done) begin
                if (rdq.size() > 0) exp_rsp = N'(1 << rdq.pop_front());
                else m_err = 1'b1;
            end
            checkOutput("model_rsp_valid", rsp_valid, exp_rsp);
            if (exp_rsp != 0) checkOutput("model_rsp_data", rsp_data, mc_data_out);

            exp_ack = '0;
            if (mc_write_done) begin
                if (wrq.size() > 0) exp_ack = N'(1 << wrq.pop_front());
                else m_err = 1'b1;
            end
            checkOutput("model_wr_ack", wr_ack, exp_ack);

            if (m_xfer) begin
                if (m_type) wrq.push_back(m_id);
                else rdq.push_back(m_id);
            end
            if (gi >= 0) begin
                m_valid = 1'b1;
                m_type  = req_type[gi];
                m_addr  = req_addr[gi*AW +: AW];
                m_data  = req_data[gi*DW +: DW];
                m_id    = gi;
                m_rr    = (gi + 1) % N;
            end else if (m_xfer) begin
                m_valid = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = (i == 2) ? 30'h5 : 30'h100 + 30'(i * 'h11);
            req_data[i*DW +: DW] = 16'hD000 + 16'(i);
        end

        // Reset with everyone requesting: nothing may be granted.
        applyStimulus(4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 16'h0);
        tick();
        tick();
        checkOutput("rst_req_ready", req_ready, 0);
        checkOutput("rst_mc_valid", mc_valid, 0);
        checkOutput("rst_err", err_underflow, 0);
        rst = 1'b0;

        // Four writers, controller always free: 0,1,2,3,0 back to back.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("rr_grant", req_ready, 32'd1 << (k % 4));
            if (k > 0) checkOutput("rr_mc_valid", mc_valid, 1);
            tick();
        end
        applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        checkOutput("drain_mc_valid", mc_valid, 1);
        tick();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 16'h0);
            @(negedge clk);
            checkOutput("wr_ack_order", wr_ack, 32'd1 << (k % 4));
            tick();
        end

        // Requester 2 reads 0x5 while the controller stalls for 3 cycles.
        applyStimulus(4'b0100, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        checkOutput("r2_grant", req_ready, 4'b0100);
        tick();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'h0, 4'h0, (k < 3), 1'b0, 1'b0, 16'h0);
            @(negedge clk);
            checkOutput("stall_mc_valid", mc_valid, 1);
            checkOutput("stall_mc_addr", mc_addr, 30'h5);
            checkOutput("stall_mc_type", mc_type, 0);
            tick();
        end
        applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 16'h00AB);
        @(negedge clk);
        checkOutput("r2_rsp_valid", rsp_valid, 4'b0100);
        checkOutput("r2_rsp_data", rsp_data, 16'h00AB);
        tick();

        // Requester 1 reads until all 16 read tags are committed.
        applyStimulus(4'b0010, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            checkOutput("fill_grant", req_ready, (k < 16) ? 4'b0010 : 4'b0000);
            tick();
        end
        applyStimulus(4'b1010, 4'b1000, 1'b0, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        checkOutput("full_write_grant", req_ready, 4'b1000);
        tick();
        applyStimulus(4'b0010, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        checkOutput("full_read_blocked", req_ready, 0);
        tick();
        applyStimulus(4'b0010, 4'h0, 1'b0, 1'b0, 1'b1, 16'h1234);
        @(negedge clk);
        checkOutput("full_rsp_valid", rsp_valid, 4'b0010);
        checkOutput("full_done_no_grant", req_ready, 0);
        tick();
        applyStimulus(4'b0010, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        checkOutput("read_resumes", req_ready, 4'b0010);
        tick();
        applyStimulus(4'b0010, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        checkOutput("busy_no_grant", req_ready, 0);
        tick();
        // Push and pop of the read tags in the same cycle at full budget.
        applyStimulus(4'b0010, 4'h0, 1'b0, 1'b0, 1'b1, 16'h4321);
        @(negedge clk);
        checkOutput("pushpop_rsp_valid", rsp_valid, 4'b0010);
        checkOutput("pushpop_rsp_data", rsp_data, 16'h4321);
        checkOutput("pushpop_no_grant", req_ready, 0);
        tick();
        @(negedge clk);
        checkOutput("pushpop_regrant", req_ready, 4'b0010);
        tick();
        applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        tick();

        // Reset while a write sits in the stage and tags are outstanding.
        applyStimulus(4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        checkOutput("pre_rst_grant", req_ready, 4'b0001);
        tick();
        applyStimulus(4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_mc_valid", mc_valid, 0);
        checkOutput("midrst_req_ready", req_ready, 0);
        tick();
        rst = 1'b0;

        applyStimulus(4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 16'h0);
        @(negedge clk);
        checkOutput("uflow_no_ack", wr_ack, 0);
        checkOutput("uflow_err_before", err_underflow, 0);
        tick();
        applyStimulus(4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        checkOutput("post_rst_rr", req_ready, 4'b0001);
        checkOutput("uflow_err_set", err_underflow, 1);
        tick();
        applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 16'hBEEF);
        @(negedge clk);
        checkOutput("uflow_no_rsp", rsp_valid, 0);
        checkOutput("uflow_err_sticky", err_underflow, 1);
        tick();
        applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        tick();
        applyStimulus(4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 16'h0);
        @(negedge clk);
        checkOutput("post_rst_wr_ack", wr_ack, 4'b0001);
        checkOutput("err_still_set", err_underflow, 1);
        tick();
        applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("err_cleared_in_rst", err_underflow, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("err_cleared_after_rst", err_underflow, 0);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
